// File: rtl/tcm_mem_pipe_if.sv
// Core-side fetch and data buses of the pipelined TCM; the core drives requests
// through the master modport, the memory answers through the slave modport.
interface tcm_mem_pipe_if #(
  parameter int TAG_W = 11
);
  logic              mem_i_rd;
  logic              mem_i_flush;
  logic              mem_i_invalidate;
  logic [31:0]       mem_i_pc;
  logic              mem_i_accept;
  logic              mem_i_valid;
  logic              mem_i_error;
  logic [31:0]       mem_i_inst;

  logic [31:0]       mem_d_addr;
  logic [31:0]       mem_d_data_wr;
  logic              mem_d_rd;
  logic [3:0]        mem_d_wr;
  logic              mem_d_cacheable;
  logic [TAG_W-1:0]  mem_d_req_tag;
  logic              mem_d_invalidate;
  logic              mem_d_flush;
  logic              mem_d_accept;
  logic              mem_d_ack;
  logic              mem_d_error;
  logic [31:0]       mem_d_data_rd;
  logic [TAG_W-1:0]  mem_d_resp_tag;

  modport master (
    output mem_i_rd, mem_i_flush, mem_i_invalidate, mem_i_pc,
    input  mem_i_accept, mem_i_valid, mem_i_error, mem_i_inst,
    output mem_d_addr, mem_d_data_wr, mem_d_rd, mem_d_wr, mem_d_cacheable,
    output mem_d_req_tag, mem_d_invalidate, mem_d_flush,
    input  mem_d_accept, mem_d_ack, mem_d_error, mem_d_data_rd, mem_d_resp_tag
  );

  modport slave (
    input  mem_i_rd, mem_i_flush, mem_i_invalidate, mem_i_pc,
    output mem_i_accept, mem_i_valid, mem_i_error, mem_i_inst,
    input  mem_d_addr, mem_d_data_wr, mem_d_rd, mem_d_wr, mem_d_cacheable,
    input  mem_d_req_tag, mem_d_invalidate, mem_d_flush,
    output mem_d_accept, mem_d_ack, mem_d_error, mem_d_data_rd, mem_d_resp_tag
  );
endinterface

// File: rtl/tcm_mem_pipe.sv
// Dual-port tightly-coupled memory with range checking and a LATENCY-deep response
// pipeline per port; responses arrive LATENCY cycles after the request, no backpressure.
module tcm_mem_pipe #(
  parameter int          ADDR_W    = 15,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 1,
  parameter int          TAG_W     = 11
) (
  input logic            clk_i,
  input logic            rst_i,
  tcm_mem_pipe_if.slave  bus
);
  localparam int          DEPTH = 1 << ADDR_W;
  localparam logic [32:0] SPAN  = 33'd4 << ADDR_W;

  logic [31:0] ram [DEPTH];

  logic [31:0]       i_off, d_off;
  logic              i_hit, d_hit;
  logic [ADDR_W-1:0] i_idx, d_idx;
  logic              i_req, d_req, d_access;

  logic              i_vld [LATENCY];
  logic              i_err [LATENCY];
  logic [31:0]       i_dat [LATENCY];
  logic              d_vld [LATENCY];
  logic              d_err [LATENCY];
  logic [TAG_W-1:0]  d_tag [LATENCY];
  logic [31:0]       d_dat [LATENCY];

  assign i_off    = bus.mem_i_pc - BASE_ADDR;
  assign d_off    = bus.mem_d_addr - BASE_ADDR;
  assign i_hit    = {1'b0, i_off} < SPAN;
  assign d_hit    = {1'b0, d_off} < SPAN;
  assign i_idx    = i_off[ADDR_W+1:2];
  assign d_idx    = d_off[ADDR_W+1:2];
  assign d_access = bus.mem_d_rd || (bus.mem_d_wr != 4'b0000);
  assign i_req    = !rst_i && bus.mem_i_rd;
  assign d_req    = !rst_i && (d_access || bus.mem_d_flush || bus.mem_d_invalidate);

  always @(posedge clk_i) begin
    if (!rst_i && d_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_d_wr[b]) ram[d_idx][8*b +: 8] <= bus.mem_d_data_wr[8*b +: 8];
      end
    end
  end

  // Payload only moves with a valid beat, so the last stage holds its response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < LATENCY; s++) begin
        i_vld[s] <= 1'b0;
        i_err[s] <= 1'b0;
        i_dat[s] <= 32'h0;
        d_vld[s] <= 1'b0;
        d_err[s] <= 1'b0;
        d_tag[s] <= '0;
        d_dat[s] <= 32'h0;
      end
    end else begin
      i_vld[0] <= i_req;
      if (i_req) begin
        i_err[0] <= !i_hit;
        i_dat[0] <= i_hit ? ram[i_idx] : 32'h0;
      end
      d_vld[0] <= d_req;
      if (d_req) begin
        d_err[0] <= d_access && !d_hit;
        d_tag[0] <= bus.mem_d_req_tag;
        d_dat[0] <= (bus.mem_d_rd && d_hit) ? ram[d_idx] : 32'h0;
      end
      for (int s = 1; s < LATENCY; s++) begin
        i_vld[s] <= i_vld[s-1] && !bus.mem_i_flush;
        if (i_vld[s-1] && !bus.mem_i_flush) begin
          i_err[s] <= i_err[s-1];
          i_dat[s] <= i_dat[s-1];
        end
        d_vld[s] <= d_vld[s-1];
        if (d_vld[s-1]) begin
          d_err[s] <= d_err[s-1];
          d_tag[s] <= d_tag[s-1];
          d_dat[s] <= d_dat[s-1];
        end
      end
    end
  end

  assign bus.mem_i_accept   = 1'b1;
  assign bus.mem_i_valid    = i_vld[LATENCY-1];
  assign bus.mem_i_error    = i_err[LATENCY-1];
  assign bus.mem_i_inst     = i_dat[LATENCY-1];
  assign bus.mem_d_accept   = 1'b1;
  assign bus.mem_d_ack      = d_vld[LATENCY-1];
  assign bus.mem_d_error    = d_err[LATENCY-1];
  assign bus.mem_d_resp_tag = d_tag[LATENCY-1];
  assign bus.mem_d_data_rd  = d_dat[LATENCY-1];

  logic unused;
  assign unused = &{1'b0, bus.mem_i_invalidate, bus.mem_d_cacheable,
                    i_off[1:0], d_off[1:0], i_off[31:ADDR_W+2], d_off[31:ADDR_W+2]};

  // Backdoor byte store for preloading images in simulation.
  task automatic write(input logic [31:0] addr, input logic [7:0] value);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    if ({1'b0, off} < SPAN) ram[off[ADDR_W+1:2]][8*off[1:0] +: 8] <= value;
  endtask
endmodule
